// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Valid/ready handshake in and out. Results are held until the next operation completes.
module seq_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  quo_q;
  logic [W:0]    prem_q;
  logic [CW-1:0] cnt_q;

  logic [W+1:0]  shifted;
  logic [W+1:0]  diff;
  logic          qbit;
  logic [W:0]    prem_nx;
  logic          last;
  logic          dvs_zero;

  // The extra top bit of the subtraction is the borrow; no borrow means quotient bit 1.
  always_comb begin
    shifted  = {prem_q, dvd_q[W-1]};
    diff     = shifted - {2'b00, dvs_q};
    qbit     = ~diff[W+1];
    prem_nx  = qbit ? diff[W:0] : shifted[W:0];
    last     = (cnt_q == CW'(W - 1));
    dvs_zero = (dvs_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (dvs_zero || last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            quo_q  <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          if (dvs_zero) begin
            quot        <= '1;
            rem         <= dvd_q;
            div_by_zero <= 1'b1;
          end else begin
            dvd_q  <= dvd_q << 1;
            prem_q <= prem_nx;
            quo_q  <= {quo_q[W-2:0], qbit};
            cnt_q  <= cnt_q + CW'(1);
            if (last) begin
              quot        <= {quo_q[W-2:0], qbit};
              rem         <= prem_nx[W-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed vector bench for seq_div (W=8)
module tb_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int acc    = 0;

  seq_div #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Handshake inputs are stable at the falling edge; count acceptances there.
  always @(negedge clk) if (in_valid && in_ready) acc++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for out_valid after an acceptance edge; returns number of edges taken.
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (lat < 20) begin
      if (scramble) begin
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic do_op(input vec_t v, input string name);
    int lat;
    in_valid = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, " busy in_ready"}, 32'(in_ready), 32'd0);
    wait_done(1'b1, lat);
    chk({name, " latency"}, 32'(lat), 32'(v.lat));
    chk({name, " quot"}, 32'(quot), 32'(v.q));
    chk({name, " rem"}, 32'(rem), 32'(v.r));
    chk({name, " dbz"}, 32'(div_by_zero), 32'(v.z));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " idle in_ready"}, 32'(in_ready), 32'd1);
    chk({name, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   lat;
    int   acc0;
    vec_t v;

    vecs[0]  = '{a: 100, b: 7,   q: 14,  r: 2,   z: 0, lat: 8};
    vecs[1]  = '{a: 255, b: 1,   q: 255, r: 0,   z: 0, lat: 8};
    vecs[2]  = '{a: 3,   b: 10,  q: 0,   r: 3,   z: 0, lat: 8};
    vecs[3]  = '{a: 5,   b: 0,   q: 255, r: 5,   z: 1, lat: 1};
    vecs[4]  = '{a: 0,   b: 1,   q: 0,   r: 0,   z: 0, lat: 8};
    vecs[5]  = '{a: 0,   b: 0,   q: 255, r: 0,   z: 1, lat: 1};
    vecs[6]  = '{a: 255, b: 255, q: 1,   r: 0,   z: 0, lat: 8};
    vecs[7]  = '{a: 254, b: 255, q: 0,   r: 254, z: 0, lat: 8};
    vecs[8]  = '{a: 128, b: 2,   q: 64,  r: 0,   z: 0, lat: 8};
    vecs[9]  = '{a: 255, b: 16,  q: 15,  r: 15,  z: 0, lat: 8};
    vecs[10] = '{a: 37,  b: 37,  q: 1,   r: 0,   z: 0, lat: 8};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quot", 32'(quot), 32'd0);
    chk("reset rem", 32'(rem), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // 200/9 with a stalled consumer
    in_valid = 1'b1; dividend = 200; divisor = 9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(1'b1, lat);
    chk("stall latency", 32'(lat), 32'd8);
    for (int c = 0; c < 5; c++) begin
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall quot", 32'(quot), 32'd22);
      chk("stall rem", 32'(rem), 32'd2);
      chk("stall dbz", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release in_ready", 32'(in_ready), 32'd1);
    chk("stall release out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of 100/7
    in_valid = 1'b1; dividend = 100; divisor = 7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort quot", 32'(quot), 32'd0);
    chk("abort rem", 32'(rem), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort post-edge out_valid", 32'(out_valid), 32'd0);
    chk("abort post-edge in_ready", 32'(in_ready), 32'd1);
    v = '{a: 50, b: 5, q: 10, r: 0, z: 0, lat: 8};
    do_op(v, "after_abort");

    // in_valid held high with changing operands: one acceptance per operation
    acc0 = acc;
    in_valid = 1'b1; dividend = 60; divisor = 7;
    @(posedge clk); #1;
    wait_done(1'b1, lat);
    chk("stream0 latency", 32'(lat), 32'd8);
    chk("stream0 quot", 32'(quot), 32'd8);
    chk("stream0 rem", 32'(rem), 32'd4);
    dividend = 77; divisor = 6;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stream idle in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("stream1 accepted", 32'(in_ready), 32'd0);
    wait_done(1'b1, lat);
    in_valid = 1'b0;
    chk("stream1 latency", 32'(lat), 32'd8);
    chk("stream1 quot", 32'(quot), 32'd12);
    chk("stream1 rem", 32'(rem), 32'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("stream acceptances", 32'(acc - acc0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand and result width in bits (W >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 The block SHALL have port dividend, input, W bits: unsigned dividend.
REQ-007 The block SHALL have port divisor, input, W bits: unsigned divisor.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port quot, output, W bits: unsigned quotient.
REQ-011 The block SHALL have port rem, output, W bits: unsigned remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the result came from divisor == 0.

Function
REQ-013 The block SHALL implement a multi-cycle restoring division, one quotient bit per cycle, and SHALL act as the inverse operation and counterpart of the registered multiplier.
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 out_valid SHALL be 1 only in DONE.
REQ-017 An input handshake (in_valid && in_ready) at edge k SHALL capture dividend and divisor into internal registers and move the FSM IDLE -> BUSY.
REQ-018 Changes on dividend or divisor after edge k SHALL have no effect on the result.
REQ-019 In BUSY, each edge SHALL shift in one quotient bit, MSB first, and SHALL increment a cycle counter of ceil(log2(W+1)) bits.
REQ-020 The partial remainder SHALL be held at W+1 bits; when (shifted remainder - divisor) is non-negative, the quotient bit SHALL be 1 and the difference SHALL be kept, otherwise the quotient bit SHALL be 0 and the shifted remainder SHALL be kept.
REQ-021 After the W-th BUSY edge (edge k+W), the FSM SHALL enter DONE with out_valid=1, quot = floor(dividend/divisor) and rem = dividend mod divisor; latency is therefore exactly W edges from acceptance.
REQ-022 Divisor == 0 SHALL skip iteration: at edge k+1 the FSM SHALL enter DONE with quot = all ones, rem = dividend and div_by_zero=1.
REQ-023 div_by_zero SHALL be 0 for every nonzero divisor.
REQ-024 In DONE with out_ready=0, quot, rem, div_by_zero and out_valid SHALL be held stable.
REQ-025 An output handshake (out_valid && out_ready) at an edge SHALL move the FSM DONE -> IDLE, with in_ready=1 in the following cycle.
REQ-026 No new operand SHALL be accepted in the same cycle as the output handshake (minimum initiation interval W+2 cycles).
REQ-027 in_valid asserted while the FSM is in BUSY or DONE SHALL be ignored; the upstream source holds its operands until in_ready=1.
REQ-028 quot, rem and div_by_zero SHALL keep the last completed result while in IDLE and BUSY; they are meaningful only when out_valid=1.
REQ-029 The inputs dividend == 0, divisor == 1 and dividend < divisor SHALL each produce correct results with full W-cycle latency.

Reset
REQ-030 rst_n=0 SHALL, immediately and without a clock, force state IDLE, in_ready=1, out_valid=0, quot=0, rem=0, div_by_zero=0 and counter=0.
REQ-031 Reset asserted in BUSY or DONE SHALL abort the operation; no result from the aborted operation SHALL ever appear on the outputs.
REQ-032 Release of rst_n SHALL be synchronised externally; the block SHALL accept operands on the first edge after release.

Verification
REQ-033 The bench SHALL check W=8, 100/7 accepted at edge k -> at edge k+8 out_valid=1, quot=14, rem=2, div_by_zero=0.
REQ-034 The bench SHALL check 255/1 -> quot=255, rem=0; and 3/10 -> quot=0, rem=3; both with 8-cycle latency.
REQ-035 The bench SHALL check 5/0 -> at edge k+1 out_valid=1, quot=255, rem=5, div_by_zero=1.
REQ-036 The bench SHALL check 200/9 with out_ready held 0 for 5 cycles -> quot=22, rem=2 held stable with out_valid=1 throughout; with out_ready=1, IDLE next cycle.
REQ-037 The bench SHALL check rst_n pulsed low at edge k+4 of 100/7 -> out_valid=0 and in_ready=1 immediately; a subsequent 50/5 -> quot=10, rem=0.
REQ-038 The bench SHALL check in_valid held 1 continuously with changing operands -> exactly one acceptance per operation, and the results match the operands present at each accepting edge.
